// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the pc_sequencer slice
//   RESET_PC     : nextpc value driven while rst is high
//   TRAP_VEC     : trap redirect target (used only when PC_SEQ_TRAP_EN is defined)
//   pcs_state_e  : sequencer FSM states
//   pcs_cause_e  : redirect cause chosen by pc_src_mux
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  typedef enum logic [1:0] {
    PCS_RUN,
    PCS_STALL,
    PCS_HALT
  } pcs_state_e;

  typedef enum logic [2:0] {
    CAUSE_SEQ,
    CAUSE_STALL,
    CAUSE_JMP,
    CAUSE_BR,
    CAUSE_HALT,
    CAUSE_TRAP,
    CAUSE_HOLD
  } pcs_cause_e;

endpackage

// File: rtl/pc_src_mux.sv
// rtl/pc_src_mux.sv - combinational priority select of nextpc, pc_en, flushes and cause
//   Build option: PC_SEQ_TRAP_EN adds trap_req_i as the highest priority request.
//   hold_i                : sequencer is halted, everything ignored
//   *_req_i               : already-qualified requests (valid bits applied by caller)
//   pc_i / pcadd4_i       : current PC and its sequential successor
//   jmp_target_i/br_target_i : redirect targets
//   nextpc_o, pc_en_o, flush_if_id_o, flush_id_ex_o, cause_o : selection result
module pc_src_mux
  import cpu_pkg::*;
(
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap_req_i,
`endif
  input  logic        hold_i,
  input  logic        halt_req_i,
  input  logic        br_req_i,
  input  logic        jmp_req_i,
  input  logic        stall_req_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcadd4_i,
  input  logic [31:0] jmp_target_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] nextpc_o,
  output logic        pc_en_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output pcs_cause_e  cause_o
);

  always_comb begin
    nextpc_o      = pcadd4_i;
    pc_en_o       = 1'b1;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    cause_o       = CAUSE_SEQ;

    if (hold_i) begin
      nextpc_o = pc_i;
      pc_en_o  = 1'b0;
      cause_o  = CAUSE_HOLD;
    end
`ifdef PC_SEQ_TRAP_EN
    else if (trap_req_i) begin
      nextpc_o      = TRAP_VEC;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      cause_o       = CAUSE_TRAP;
    end
`endif
    else if (halt_req_i) begin
      nextpc_o      = pc_i;
      pc_en_o       = 1'b0;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      cause_o       = CAUSE_HALT;
    end else if (br_req_i) begin
      // Branch in EX beats stall/jump in ID: those instructions are younger
      // and are on the wrong path.
      nextpc_o      = br_target_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      cause_o       = CAUSE_BR;
    end else if (jmp_req_i) begin
      nextpc_o      = jmp_target_i;
      flush_if_id_o = 1'b1;
      cause_o       = CAUSE_JMP;
    end else if (stall_req_i) begin
      nextpc_o = pc_i;
      pc_en_o  = 1'b0;
      cause_o  = CAUSE_STALL;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller: source select, flush strobes, stage valid bits
//   Build option: PC_SEQ_TRAP_EN adds trap_i/ex_pc_i inputs and the epc output.
//   clk, rst                  : clock, synchronous active-high reset
//   pc, pcadd4                : PC register value and pc+4
//   stall_i, jmp_i, jmp_target_i : ID-stage requests (qualified by id_valid)
//   br_taken_i, br_target_i, halt_i : EX-stage requests (qualified by ex_valid)
//   nextpc, pc_en             : PC register next value and load enable
//   flush_if_id, flush_id_ex  : pipeline register clear strobes
//   id_valid, ex_valid, halted: registered status
module pc_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pcadd4,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        halt_i,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap_i,
  input  logic [31:0] ex_pc_i,
  output logic [31:0] epc,
`endif
  output logic [31:0] nextpc,
  output logic        pc_en,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        id_valid,
  output logic        ex_valid,
  output logic        halted
);

  pcs_state_e  state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic        ex_valid_q, ex_valid_d;

  logic        halt_st;
  logic [31:0] mux_nextpc;
  logic        mux_pc_en;
  logic        mux_flush_if_id;
  logic        mux_flush_id_ex;
  pcs_cause_e  cause;
  logic        stall_eff;

  assign halt_st = (state_q == PCS_HALT);

  pc_src_mux u_src_mux (
`ifdef PC_SEQ_TRAP_EN
    .trap_req_i    (trap_i & ex_valid_q),
`endif
    .hold_i        (halt_st),
    .halt_req_i    (halt_i & ex_valid_q),
    .br_req_i      (br_taken_i & ex_valid_q),
    .jmp_req_i     (jmp_i & id_valid_q),
    .stall_req_i   (stall_i & id_valid_q),
    .pc_i          (pc),
    .pcadd4_i      (pcadd4),
    .jmp_target_i  (jmp_target_i),
    .br_target_i   (br_target_i),
    .nextpc_o      (mux_nextpc),
    .pc_en_o       (mux_pc_en),
    .flush_if_id_o (mux_flush_if_id),
    .flush_id_ex_o (mux_flush_id_ex),
    .cause_o       (cause)
  );

  // A stall only counts when it actually won the priority select; a stall
  // overridden by a jump or branch must not freeze ID or bubble EX.
  assign stall_eff = (cause == CAUSE_STALL);

  // Reset forces a fetch from RESET_PC and clears both pipeline registers.
  always_comb begin
    nextpc      = mux_nextpc;
    pc_en       = mux_pc_en;
    flush_if_id = mux_flush_if_id;
    flush_id_ex = mux_flush_id_ex;
    if (rst) begin
      nextpc      = RESET_PC;
      pc_en       = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (cause)
      CAUSE_HOLD,
      CAUSE_HALT:  state_d = PCS_HALT;
      CAUSE_STALL: state_d = PCS_STALL;
      default:     state_d = PCS_RUN;
    endcase
  end

  always_comb begin
    id_valid_d = 1'b1;
    if (halt_st || mux_flush_if_id) begin
      id_valid_d = 1'b0;
    end else if (stall_eff) begin
      id_valid_d = id_valid_q;
    end

    ex_valid_d = id_valid_q;
    if (halt_st || mux_flush_id_ex || stall_eff) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PCS_RUN;
      id_valid_q <= 1'b0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc_q, epc_d;

  always_comb begin
    epc_d = epc_q;
    if (cause == CAUSE_TRAP) begin
      epc_d = ex_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= 32'h0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;
`endif

  assign id_valid = id_valid_q;
  assign ex_valid = ex_valid_q;
  assign halted   = halt_st;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        en;
    logic        fif;
    logic        fie;
    logic        idv;
    logic        exv;
    logic        hlt;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] pcadd4;
  logic        stall_i = 1'b0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_target_i = 32'h0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = 32'h0;
  logic        halt_i = 1'b0;
  logic        trap_i = 1'b0;
  logic [31:0] ex_pc_i = 32'h0;
  logic [31:0] epc_act;
  logic [31:0] nextpc;
  logic        pc_en, flush_if_id, flush_id_ex, id_valid, ex_valid, halted;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pcadd4       (pcadd4),
    .stall_i      (stall_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .halt_i       (halt_i),
`ifdef PC_SEQ_TRAP_EN
    .trap_i       (trap_i),
    .ex_pc_i      (ex_pc_i),
    .epc          (epc_act),
`endif
    .nextpc       (nextpc),
    .pc_en        (pc_en),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .id_valid     (id_valid),
    .ex_valid     (ex_valid),
    .halted       (halted)
  );

`ifndef PC_SEQ_TRAP_EN
  assign epc_act = 32'h0;
`endif

  // Environment PC register fed by the sequencer.
  always @(posedge clk) if (pc_en) pc <= nextpc;
  assign pcadd4 = pc + 32'd4;

  function automatic exp_t mk(logic [31:0] p, logic [31:0] n, logic en, logic fif, logic fie,
                              logic idv, logic exv, logic hlt, logic [31:0] e);
    exp_t x;
    x.pc = p; x.npc = n; x.en = en; x.fif = fif; x.fie = fie;
    x.idv = idv; x.exv = exv; x.hlt = hlt; x.epc = e;
    return x;
  endfunction

  task automatic vec(input string nm, input logic r, input logic s, input logic j,
                     input logic [31:0] jt, input logic b, input logic [31:0] bt,
                     input logic h, input logic t, input logic [31:0] xpc, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; stall_i = s; jmp_i = j; jmp_target_i = jt;
    br_taken_i = b; br_target_i = bt; halt_i = h; trap_i = t; ex_pc_i = xpc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle is an output beat; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = mk(pc, nextpc, pc_en, flush_if_id, flush_id_ex, id_valid, ex_valid, halted, epc_act);
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got pc=%h npc=%h en=%b fif=%b fie=%b idv=%b exv=%b hlt=%b epc=%h, want pc=%h npc=%h en=%b fif=%b fie=%b idv=%b exv=%b hlt=%b epc=%h",
                 nm, a.pc, a.npc, a.en, a.fif, a.fie, a.idv, a.exv, a.hlt, a.epc,
                 e.pc, e.npc, e.en, e.fif, e.fie, e.idv, e.exv, e.hlt, e.epc);
      end
    end
  end

  initial begin
    logic [31:0] ep;
    ep = 32'h0;
    //       name          rst st jm jt        br bt           hl tr xpc          pc            npc           en fif fie idv exv hlt epc
    vec("reset",          1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h0,       32'h0,        1, 1, 1, 0, 0, 0, ep));
    vec("run0",           0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h0,       32'h4,        1, 0, 0, 0, 0, 0, ep));
    vec("run4",           0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h4,       32'h8,        1, 0, 0, 1, 0, 0, ep));
    vec("run8",           0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h8,       32'hC,        1, 0, 0, 1, 1, 0, ep));
    vec("run12",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'hC,       32'h10,       1, 0, 0, 1, 1, 0, ep));
    vec("stall1",         0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h10,      32'h10,       0, 0, 0, 1, 1, 0, ep));
    vec("stall2",         0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h10,      32'h10,       0, 0, 0, 1, 0, 0, ep));
    vec("stall3",         0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h10,      32'h10,       0, 0, 0, 1, 0, 0, ep));
    vec("unstall",        0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h10,      32'h14,       1, 0, 0, 1, 0, 0, ep));
    vec("run14",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h14,      32'h18,       1, 0, 0, 1, 1, 0, ep));
    vec("run18",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h18,      32'h1C,       1, 0, 0, 1, 1, 0, ep));
    vec("run1c",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h1C,      32'h20,       1, 0, 0, 1, 1, 0, ep));
    vec("jump",           0, 0, 1, 32'h100, 0, 32'h0,        0, 0, 32'h0,  mk(32'h20,      32'h100,      1, 1, 0, 1, 1, 0, ep));
    vec("jmp_bubble",     0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h100,     32'h104,      1, 0, 0, 0, 1, 0, ep));
    vec("br_ignored",     0, 0, 0, 32'h0,   1, 32'h500,      0, 0, 32'h0,  mk(32'h104,     32'h108,      1, 0, 0, 1, 0, 0, ep));
    vec("run108",         0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h108,     32'h10C,      1, 0, 0, 1, 1, 0, ep));
    vec("br_over_st_jmp", 0, 1, 1, 32'h200, 1, 32'h40,       0, 0, 32'h0,  mk(32'h10C,     32'h40,       1, 1, 1, 1, 1, 0, ep));
    vec("jmp_ignored",    0, 0, 1, 32'h300, 0, 32'h0,        0, 0, 32'h0,  mk(32'h40,      32'h44,       1, 0, 0, 0, 0, 0, ep));
    vec("run44",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h44,      32'h48,       1, 0, 0, 1, 0, 0, ep));
    vec("halt",           0, 0, 0, 32'h0,   0, 32'h0,        1, 0, 32'h0,  mk(32'h48,      32'h48,       0, 1, 1, 1, 1, 0, ep));
    vec("halted_reqs",    0, 1, 1, 32'h300, 1, 32'h700,      1, 0, 32'h0,  mk(32'h48,      32'h48,       0, 0, 0, 0, 0, 1, ep));
    vec("halted_idle",    0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h48,      32'h48,       0, 0, 0, 0, 0, 1, ep));
    vec("reset_mid",      1, 0, 0, 32'h0,   1, 32'h700,      0, 0, 32'h0,  mk(32'h48,      32'h0,        1, 1, 1, 0, 0, 1, ep));
    vec("after_reset",    0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h0,       32'h4,        1, 0, 0, 0, 0, 0, ep));
    vec("run4b",          0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h4,       32'h8,        1, 0, 0, 1, 0, 0, ep));
    vec("br_to_top",      0, 0, 0, 32'h0,   1, 32'hFFFF_FFFC, 0, 0, 32'h0, mk(32'h8,       32'hFFFF_FFFC, 1, 1, 1, 1, 1, 0, ep));
    vec("wrap_st_ign",    0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'hFFFF_FFFC, 32'h0,      1, 0, 0, 0, 0, 0, ep));
    vec("wrapped",        0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h0,       32'h4,        1, 0, 0, 1, 0, 0, ep));
`ifdef PC_SEQ_TRAP_EN
    vec("trap",           0, 0, 0, 32'h0,   1, 32'h600,      0, 1, 32'h2C, mk(32'h4,       32'h80,       1, 1, 1, 1, 1, 0, 32'h0));
    vec("after_trap",     0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,  mk(32'h80,      32'h84,       1, 0, 0, 0, 0, 0, 32'h2C));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0; stall_i = 1'b0; jmp_i = 1'b0; br_taken_i = 1'b0; halt_i = 1'b0; trap_i = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected beats left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
